// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings, the default register-address width and the control-vector presets live here.
package hazard_controller_pkg;

    localparam int unsigned REGS_WIDTH_DEF = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    // Pipeline control vector produced by the priority logic
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_hold;
        logic md_busy;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_RESET  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_MD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The master modport is the pipeline side; the slave modport is the controller.
interface hazard_controller_if #(
    parameter int unsigned REGS_WIDTH = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REGS_WIDTH-1:0] id_rs1;
    logic [REGS_WIDTH-1:0] id_rs2;
    logic                  id_is_md;
    logic                  ex_wr_reg;
    logic [REGS_WIDTH-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  mem_wr_reg;
    logic [REGS_WIDTH-1:0] mem_rd;
    logic                  ex_branch_taken;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_hold;
    logic                  md_busy;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_is_md,
               ex_wr_reg, ex_rd, ex_is_load, mem_wr_reg, mem_rd, ex_branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, md_busy, stall_cycles
    );

    modport slave (
        input  id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_is_md,
               ex_wr_reg, ex_rd, ex_is_load, mem_wr_reg, mem_rd, ex_branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, md_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_md_timer.sv
// Multi-cycle (mul/div) occupancy timer: RUN/MD_BUSY FSM with a down-counter.
// EX is held for MD_LATENCY-1 cycles after the op enters EX.
module hazard_md_timer
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic md_busy_o
);

    localparam int unsigned CNT_BITS = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MD_LATENCY - 2);

    md_state_e           state_q;
    logic [CNT_BITS-1:0] md_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (start_i) begin
                        state_q  <= ST_MD_BUSY;
                        md_cnt_q <= CNT_LOAD;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        md_cnt_q <= md_cnt_q - CNT_BITS'(1);
                    end
                end
            endcase
        end
    end

    // Reset forces the idle view immediately, even mid-op
    assign md_busy_o = (state_q == ST_MD_BUSY) && !rst;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use / RAW stall detection, branch flush and mul/div hold.
// Define FORWARDING_EN when EX and MEM results are forwarded (only load-use then stalls).
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REGS_WIDTH = REGS_WIDTH_DEF,
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  bus
);

    logic [REGS_WIDTH-1:0] rs1;
    logic [REGS_WIDTH-1:0] rs2;
    logic [REGS_WIDTH-1:0] ex_rd;
    logic                  rs1_live;
    logic                  rs2_live;
    logic                  load_use;
    logic                  data_stall;
    logic                  md_busy;
    logic                  md_start;
    hz_ctrl_t              ctrl_c;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;

    assign rs1   = bus.id_rs1;
    assign rs2   = bus.id_rs2;
    assign ex_rd = bus.ex_rd;

    // x0 is never a hazard source
    assign rs1_live = bus.id_use_rs1 && (rs1 != '0);
    assign rs2_live = bus.id_use_rs2 && (rs2 != '0);

    assign load_use = bus.ex_wr_reg && bus.ex_is_load &&
                      ((rs1_live && (rs1 == ex_rd)) || (rs2_live && (rs2 == ex_rd)));

`ifdef FORWARDING_EN
    logic unused_mem;
    assign unused_mem = ^{bus.mem_wr_reg, bus.mem_rd};
    assign data_stall = load_use;
`else
    logic ex_raw;
    logic mem_raw;
    assign ex_raw  = bus.ex_wr_reg &&
                     ((rs1_live && (rs1 == ex_rd)) || (rs2_live && (rs2 == ex_rd)));
    assign mem_raw = bus.mem_wr_reg &&
                     ((rs1_live && (rs1 == bus.mem_rd)) || (rs2_live && (rs2 == bus.mem_rd)));
    assign data_stall = load_use || ex_raw || mem_raw;
`endif

    // A multi-cycle op enters EX only when it is neither stalled nor squashed
    assign md_start = bus.id_is_md && !data_stall && !bus.ex_branch_taken;

    hazard_md_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (md_start),
        .md_busy_o (md_busy)
    );

    // Priority: reset > mul/div busy > taken branch > data stall > normal
    always_comb begin
        ctrl_c = CTRL_NORMAL;
        if (rst) begin
            ctrl_c = CTRL_RESET;
        end else if (md_busy) begin
            ctrl_c = CTRL_MD;
        end else if (bus.ex_branch_taken) begin
            ctrl_c = CTRL_BRANCH;
        end else if (data_stall) begin
            ctrl_c = CTRL_STALL;
        end
    end

    assign bus.pc_en       = ctrl_c.pc_en;
    assign bus.if_id_en    = ctrl_c.if_id_en;
    assign bus.if_id_flush = ctrl_c.if_id_flush;
    assign bus.id_ex_flush = ctrl_c.id_ex_flush;
    assign bus.ex_hold     = ctrl_c.ex_hold;
    assign bus.md_busy     = ctrl_c.md_busy;

    // Saturating count of frozen-PC cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl_c.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;

endmodule
